serial_subtractor: RTL and testbench

Parametrised bit-serial subtractor computing `x - y - b_in` over `WIDTH` clock cycles with one full-subtractor cell and a borrow flip-flop. It generalises the single-bit half subtractor to N-bit operands, adds borrow-in, a signed-overflow flag and a start/busy/done handshake. It serves datapaths where area matters more than latency.

---
 rtl/serial_subtractor.sv | 103 ++++++++++
 tb/tb_serial_subtractor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: x - y - b_in, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flop; all outputs registered.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  output logic [WIDTH-1:0] diff,
  output logic             c_out,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             br_d;
  logic             d_bit;
  logic             last;
  logic             c_out_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  // Full-subtractor cell on the operand LSBs and result shift-in.
  always_comb begin
    d_bit = x_q[0] ^ y_q[0] ^ br_q;
    br_d  = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & br_q);
    res_d = res_q >> 1;
    res_d[WIDTH-1] = d_bit;
    last  = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= x;
            y_q     <= y;
            br_q    <= b_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          x_q   <= x_q >> 1;
          y_q   <= y_q >> 1;
          res_q <= res_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            diff_q  <= res_d;
            c_out_q <= br_d;
            ovf_q   <= br_q ^ br_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign diff  = diff_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances,
// directed and random operations against an arithmetic model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] x8 = '0;
  logic [7:0] y8 = '0;
  logic       b8 = 1'b0;
  logic [7:0] diff8;
  logic       c8, ovf8, busy8, done8;

  logic       start1 = 1'b0;
  logic [0:0] x1 = '0;
  logic [0:0] y1 = '0;
  logic       b1 = 1'b0;
  logic [0:0] diff1;
  logic       c1, ovf1, busy1, done1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .x(x8), .y(y8), .b_in(b8),
    .diff(diff8), .c_out(c8), .ovf(ovf8),
    .busy(busy8), .done(done8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .x(x1), .y(y1), .b_in(b1),
    .diff(diff1), .c_out(c1), .ovf(ovf1),
    .busy(busy1), .done(done1)
  );

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void model(
    input int w, input longint ux, input longint uy,
    input longint bi, output logic [31:0] d,
    output logic c, output logic v
  );
    longint m, sx, sy, r;
    m = longint'(1) << w;
    d = 32'((ux - uy - bi + m) % m);
    c = (ux < uy + bi);
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    r = sx - sy - bi;
    v = (r < -(m / 2)) || (r > m / 2 - 1);
  endfunction

  // One WIDTH=8 operation; lat=-1 if done never arrives.
  task automatic run8(
    input logic [7:0] a, input logic [7:0] b,
    input logic bi, output int lat,
    output logic bsy0, output logic dn_after
  );
    @(negedge clk);
    x8 = a; y8 = b; b8 = bi; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    bsy0 = busy8;
    x8 = 8'($urandom); y8 = 8'($urandom); b8 = 1'($urandom);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done8) begin lat = n; break; end
    end
    @(negedge clk);
    dn_after = done8;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({diff8, c8, ovf8, busy8, done8} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset8 got %h want 000",
               {diff8, c8, ovf8, busy8, done8});
    end
    n_cmp++;
    if ({diff1, c1, ovf1, busy1, done1} !== 5'h0) begin
      n_fail++;
      $display("FAIL reset1 got %h want 00",
               {diff1, c1, ovf1, busy1, done1});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] xs [5] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
    logic [7:0] ys [5] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF};
    logic       bs [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] ed [5] = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h80};
    logic       ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       ev [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    logic b0, da;
    for (int i = 0; i < 5; i++) begin
      run8(xs[i], ys[i], bs[i], lat, b0, da);
      n_cmp++;
      if (lat !== 8 || b0 !== 1'b1 || da !== 1'b0) begin
        n_fail++;
        $display("FAIL dir%0d_timing lat=%0d busy=%b done2=%b want 8/1/0",
                 i, lat, b0, da);
      end
      n_cmp++;
      if ({diff8, c8, ovf8} !== {ed[i], ec[i], ev[i]}) begin
        n_fail++;
        $display("FAIL dir%0d got %h/%b/%b want %h/%b/%b", i,
                 diff8, c8, ovf8, ed[i], ec[i], ev[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic bi, c, v, b0, da;
    logic [31:0] d;
    int lat;
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
      if (i == 0) begin a = 8'h00; b = 8'hFF; bi = 1'b1; end
      if (i == 1) begin a = 8'hFF; b = 8'h00; bi = 1'b0; end
      model(8, longint'(a), longint'(b), longint'(bi), d, c, v);
      run8(a, b, bi, lat, b0, da);
      n_cmp++;
      if (lat !== 8 || {diff8, c8, ovf8} !== {d[7:0], c, v}) begin
        n_fail++;
        $display("FAIL rnd %h-%h-%b got %h/%b/%b lat%0d want %h/%b/%b",
                 a, b, bi, diff8, c8, ovf8, lat, d[7:0], c, v);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    lat = -1;
    @(negedge clk);
    x8 = 8'h05; y8 = 8'h03; b8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 2) begin
        x8 = 8'h10; y8 = 8'h01; start8 = 1'b1;
      end
      if (n == 3) start8 = 1'b0;
      if (done8) begin lat = n; break; end
    end
    n_cmp++;
    if (lat !== 8 || diff8 !== 8'h02) begin
      n_fail++;
      $display("FAIL ignore_start got %h lat%0d want 02 lat8",
               diff8, lat);
    end
    x8 = 8'h10; y8 = 8'h01; b8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n_cmp++;
    if (busy8 !== 1'b1 || diff8 !== 8'h02) begin
      n_fail++;
      $display("FAIL restart_hold busy=%b diff=%h want 1/02",
               busy8, diff8);
    end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done8) begin lat = n; break; end
    end
    n_cmp++;
    if (lat !== 8 || diff8 !== 8'h0F) begin
      n_fail++;
      $display("FAIL restart got %h lat%0d want 0F lat8", diff8, lat);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    int lat;
    logic b0, da;
    @(negedge clk);
    x8 = 8'h05; y8 = 8'h03; b8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({diff8, c8, ovf8, busy8, done8} !== 12'h0) begin
      n_fail++;
      $display("FAIL mid_reset got %h want 000",
               {diff8, c8, ovf8, busy8, done8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_done got %0d want 0", seen);
    end
    run8(8'h05, 8'h03, 1'b0, lat, b0, da);
    n_cmp++;
    if (lat !== 8 || {diff8, c8, ovf8} !== {8'h02, 2'b00}) begin
      n_fail++;
      $display("FAIL after_reset got %h/%b/%b lat%0d want 02/0/0 lat8",
               diff8, c8, ovf8, lat);
    end
  endtask

  task automatic test_width1();
    logic [31:0] d;
    logic c, v;
    int lat;
    for (int i = 0; i < 12; i++) begin
      logic [1:0] p;
      logic bi;
      p = 2'(i);
      bi = (i < 4) ? 1'b0 : 1'($urandom);
      model(1, longint'(p[1]), longint'(p[0]), longint'(bi), d, c, v);
      @(negedge clk);
      x1 = p[1]; y1 = p[0]; b1 = bi; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      lat = -1;
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        if (done1) begin lat = n; break; end
      end
      n_cmp++;
      if (lat !== 1 || {diff1, c1, ovf1} !== {d[0], c, v}) begin
        n_fail++;
        $display("FAIL w1 x%b y%b b%b got %b/%b/%b lat%0d want %b/%b/%b",
                 p[1], p[0], bi, diff1, c1, ovf1, lat, d[0], c, v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
